// File: rtl/sms_rx_framer.sv
// sms_rx_framer: hunts the modem UART byte stream for the SMS body marker,
// packs body bytes into 16-bit words, buffers them, and replays them to
// sms_decode as paced data_en pulses with send_state framing.
// Ports:
//   clkb        system clock, rising edge
//   rst         synchronous active-high reset
//   rx_byte     byte from the UART receiver
//   rx_valid    one-cycle strobe qualifying rx_byte
//   data_out    word to sms_decode; first byte of the pair in [15:8]
//   data_en     one-cycle pulse, data_out valid
//   send_state  0 idle/hunt, 1 message active, 2 done, 3 error
//   overflow    sticky body-too-long flag, cleared by the next start marker
//   word_count  words emitted in the current/last message (saturating)
module sms_rx_framer #(
   parameter logic [7:0]  START_CHAR = 8'h23,
   parameter int unsigned MAX_WORDS  = 16,
   parameter int unsigned EN_GAP     = 4,
   parameter int unsigned TIMEOUT    = 50000
) (
   input  logic                               clkb,
   input  logic                               rst,
   input  logic [7:0]                         rx_byte,
   input  logic                               rx_valid,
   output logic [15:0]                        data_out,
   output logic                               data_en,
   output logic [2:0]                         send_state,
   output logic                               overflow,
   output logic [$clog2(MAX_WORDS+1)-1:0]     word_count
);

   localparam int unsigned AW = $clog2(MAX_WORDS);
   localparam int unsigned CW = $clog2(MAX_WORDS + 1);
   localparam int unsigned GW = $clog2(EN_GAP + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [7:0]  CR = 8'h0D;

   typedef enum logic [2:0] {
      S_HUNT,
      S_COLLECT,
      S_DRAIN,
      S_DONE,
      S_ERR
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [15:0]    mem [MAX_WORDS];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    fifo_cnt;

   logic           stg_vld;
   logic [15:0]    stg_word;
   logic           hi_vld;
   logic [7:0]     hi_byte;
   logic [CW-1:0]  in_cnt;
   logic [GW-1:0]  gap_cnt;
   logic [TW-1:0]  tmo_cnt;

   logic           start_c;
   logic           hold_c;
   logic           form_c;
   logic [15:0]    form_word_c;
   logic           ovf_set_c;
   logic           flush_c;
   logic           pop_c;
   logic           push_c;
   logic           gap_ok_c;
   logic [2:0]     send_state_nxt_c;

   // Next-state and datapath control
   always_comb begin
      state_nxt        = state;
      start_c          = 1'b0;
      hold_c           = 1'b0;
      form_c           = 1'b0;
      form_word_c      = '0;
      ovf_set_c        = 1'b0;
      gap_ok_c         = (gap_cnt >= GW'(EN_GAP));

      case (state)
         S_HUNT: begin
            if (rx_valid && (rx_byte == START_CHAR)) begin
               start_c   = 1'b1;
               state_nxt = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (rx_valid) begin
               // A CR always closes a word; with no held byte it pairs with itself.
               if ((rx_byte == CR) || hi_vld) begin
                  if (in_cnt == CW'(MAX_WORDS)) begin
                     ovf_set_c = 1'b1;
                     state_nxt = S_ERR;
                  end else begin
                     form_c      = 1'b1;
                     form_word_c = {(hi_vld ? hi_byte : CR), rx_byte};
                     if (rx_byte == CR) begin
                        state_nxt = S_DRAIN;
                     end
                  end
               end else begin
                  hold_c = 1'b1;
               end
            end else if (tmo_cnt >= TW'(TIMEOUT)) begin
               state_nxt = S_ERR;
            end
         end
         S_DRAIN: begin
            if ((fifo_cnt == '0) && !stg_vld && gap_ok_c) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_HUNT;
         S_ERR:   state_nxt = S_HUNT;
         default: state_nxt = S_HUNT;
      endcase

      flush_c = (state_nxt == S_ERR);
      // No pulse may leave on the edge that enters ERR.
      pop_c   = ((state == S_COLLECT) || (state == S_DRAIN)) &&
                (fifo_cnt != '0) && gap_ok_c && !flush_c;
      push_c  = stg_vld && !flush_c;

      case (state_nxt)
         S_COLLECT, S_DRAIN: send_state_nxt_c = 3'd1;
         S_DONE:             send_state_nxt_c = 3'd2;
         S_ERR:              send_state_nxt_c = 3'd3;
         default:            send_state_nxt_c = 3'd0;
      endcase
   end

   // State, control counters and registered outputs
   always_ff @(posedge clkb) begin
      if (rst) begin
         state      <= S_HUNT;
         send_state <= 3'd0;
         data_out   <= '0;
         data_en    <= 1'b0;
         overflow   <= 1'b0;
         word_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         stg_vld    <= 1'b0;
         stg_word   <= '0;
         hi_vld     <= 1'b0;
         hi_byte    <= '0;
         in_cnt     <= '0;
         gap_cnt    <= GW'(EN_GAP);
         tmo_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         send_state <= send_state_nxt_c;

         // Idle-time counter since the last received byte, saturating
         if (rx_valid) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end

         // Low-time counter since the last data_en pulse, saturating
         if (pop_c) begin
            gap_cnt <= '0;
         end else if (!gap_ok_c) begin
            gap_cnt <= gap_cnt + GW'(1);
         end

         data_en <= pop_c;
         if (pop_c) begin
            data_out <= mem[rd_ptr];
            if (word_count != CW'(MAX_WORDS)) begin
               word_count <= word_count + CW'(1);
            end
         end

         if (start_c) begin
            overflow   <= 1'b0;
            word_count <= '0;
            in_cnt     <= '0;
         end else if (ovf_set_c) begin
            overflow <= 1'b1;
         end else if (form_c) begin
            in_cnt <= in_cnt + CW'(1);
         end

         if (flush_c || start_c) begin
            hi_vld <= 1'b0;
         end else if (hold_c) begin
            hi_vld  <= 1'b1;
            hi_byte <= rx_byte;
         end else if (form_c) begin
            hi_vld <= 1'b0;
         end

         // One-cycle staging between word assembly and the FIFO write
         if (flush_c) begin
            stg_vld <= 1'b0;
         end else begin
            stg_vld <= form_c;
            if (form_c) begin
               stg_word <= form_word_c;
            end
         end

         if (flush_c) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
         end else begin
            if (push_c) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
               2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
               2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
               default: fifo_cnt <= fifo_cnt;
            endcase
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clkb) begin
      if (!rst && push_c) begin
         mem[wr_ptr] <= stg_word;
      end
   end

endmodule

// File: tb/tb_sms_rx_framer.sv
// Self-checking bench for sms_rx_framer: directed scenarios plus randomized
// messages checked against a byte-pairing reference model.
module tb_sms_rx_framer;

   localparam int unsigned MAXW = 16;
   localparam int unsigned GAP  = 4;
   localparam int unsigned TMO  = 200;

   logic        clkb = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_valid = 1'b0;
   logic [15:0] data_out;
   logic        data_en;
   logic [2:0]  send_state;
   logic        overflow;
   logic [4:0]  word_count;

   sms_rx_framer #(
      .START_CHAR (8'h23),
      .MAX_WORDS  (MAXW),
      .EN_GAP     (GAP),
      .TIMEOUT    (TMO)
   ) dut (
      .clkb       (clkb),
      .rst        (rst),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .data_out   (data_out),
      .data_en    (data_en),
      .send_state (send_state),
      .overflow   (overflow),
      .word_count (word_count)
   );

   always #5 clkb = ~clkb;

   int cyc = 0;
   always @(posedge clkb) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge
   logic [15:0] got_w [$];
   int          got_c [$];
   logic [2:0]  got_ss [$];
   int          n_done = 0;
   int          n_err = 0;
   int          err_cyc = -1;

   always @(negedge clkb) begin
      if (data_en) begin
         got_w.push_back(data_out);
         got_c.push_back(cyc);
         got_ss.push_back(send_state);
      end
      if (send_state == 3'd2) n_done++;
      if (send_state == 3'd3) begin
         n_err++;
         err_cyc = cyc;
      end
   end

   int n_assert = 0;
   int n_fail = 0;
   int last_rx_cyc = 0;

   logic [7:0]  body [$];
   logic [15:0] exp_w [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: body + CR, padded with one more CR to even length, taken in pairs
   task automatic build_exp();
      logic [7:0] s [$];
      s = body;
      s.push_back(8'h0D);
      if ((s.size() % 2) != 0) s.push_back(8'h0D);
      exp_w.delete();
      for (int i = 0; i < s.size(); i += 2) exp_w.push_back({s[i], s[i+1]});
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clkb);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge clkb);
      #1;
      rx_valid    = 1'b0;
      last_rx_cyc = cyc;
      tick(gap);
   endtask

   task automatic clear_mon();
      got_w.delete();
      got_c.delete();
      got_ss.delete();
   endtask

   function automatic logic [7:0] rand_body_byte();
      logic [7:0] b;
      do b = 8'($urandom_range(0, 255)); while (b == 8'h0D);
      return b;
   endfunction

   task automatic send_msg(input int gmin, input int gmax);
      send_byte(8'h23, $urandom_range(gmin, gmax));
      foreach (body[i]) send_byte(body[i], $urandom_range(gmin, gmax));
      send_byte(8'h0D, 0);
   endtask

   task automatic wait_done(input string tag);
      int d0;
      int k;
      d0 = n_done;
      k  = 0;
      while (n_done == d0 && k < 3000) begin
         tick(1);
         k++;
      end
      chk({tag, "_done_seen"}, 32'(n_done != d0), 32'd1);
      tick(3);
      chk({tag, "_done_1cyc"}, 32'(n_done - d0), 32'd1);
      chk({tag, "_back_idle"}, 32'(send_state), 32'd0);
   endtask

   task automatic check_words(input string tag, input bit exact_gap);
      chk({tag, "_nwords"}, 32'(got_w.size()), 32'(exp_w.size()));
      for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
         chk($sformatf("%s_word%0d", tag, i), 32'(got_w[i]), 32'(exp_w[i]));
         chk($sformatf("%s_ss%0d", tag, i), 32'(got_ss[i]), 32'd1);
         if (i > 0) begin
            if (exact_gap)
               chk($sformatf("%s_space%0d", tag, i), 32'(got_c[i] - got_c[i-1]), 32'(GAP + 1));
            else
               chk($sformatf("%s_space%0d", tag, i), 32'(got_c[i] - got_c[i-1] >= GAP + 1), 32'd1);
         end
      end
      chk({tag, "_word_count"}, 32'(word_count), 32'(exp_w.size()));
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_data_out"}, 32'(data_out), 32'd0);
      chk({tag, "_data_en"}, 32'(data_en), 32'd0);
      chk({tag, "_send_state"}, 32'(send_state), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
      chk({tag, "_word_count"}, 32'(word_count), 32'd0);
   endtask

   initial begin
      int e0;
      logic [7:0] ob [$];

      // Reset state
      rst = 1'b1;
      tick(3);
      chk_outputs_zero("reset");
      rst = 1'b0;
      tick(2);

      // Basic message with an odd-length body
      body = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h33};
      build_exp();
      chk("t1_model_w2", 32'(exp_w[2]), 32'h330D);
      clear_mon();
      send_msg(0, 1);
      wait_done("t1");
      check_words("t1", 1'b0);

      // CR as odd byte, then CR as the very first body byte
      body = '{8'h41};
      build_exp();
      clear_mon();
      send_msg(1, 2);
      wait_done("t2a");
      check_words("t2a", 1'b0);
      body.delete();
      build_exp();
      clear_mon();
      send_msg(0, 0);
      wait_done("t2b");
      check_words("t2b", 1'b0);

      // Back-to-back bytes: pulses must come out at the minimum spacing
      body.delete();
      for (int i = 0; i < 8; i++) body.push_back(rand_body_byte());
      build_exp();
      clear_mon();
      send_msg(0, 0);
      wait_done("t3");
      check_words("t3", 1'b1);

      // Overflow: 34 body bytes without CR, paced so every accepted word drains
      clear_mon();
      e0 = n_err;
      ob.delete();
      for (int i = 0; i < 34; i++) ob.push_back(rand_body_byte());
      send_byte(8'h23, 2);
      for (int i = 0; i < 34; i++) send_byte(ob[i], (i == 33) ? 0 : 2);
      tick(4);
      chk("t4_err_1cyc", 32'(n_err - e0), 32'd1);
      chk("t4_overflow", 32'(overflow), 32'd1);
      chk("t4_word_count", 32'(word_count), 32'(MAXW));
      chk("t4_nwords", 32'(got_w.size()), 32'(MAXW));
      for (int i = 0; i < got_w.size() && i < MAXW; i++)
         chk($sformatf("t4_word%0d", i), 32'(got_w[i]), 32'({ob[2*i], ob[2*i+1]}));
      chk("t4_back_idle", 32'(send_state), 32'd0);
      send_byte(8'h23, 0);
      chk("t4_ovf_cleared", 32'(overflow), 32'd0);
      body.delete();
      build_exp();
      clear_mon();
      send_byte(8'h0D, 0);
      wait_done("t4b");
      check_words("t4b", 1'b0);

      // Inter-byte timeout with a half word held
      clear_mon();
      e0 = n_err;
      err_cyc = -1;
      send_byte(8'h23, 0);
      send_byte(8'h31, 0);
      tick(TMO + 20);
      chk("t5_err_1cyc", 32'(n_err - e0), 32'd1);
      chk("t5_no_data_en", 32'(got_w.size()), 32'd0);
      chk("t5_err_time", 32'((err_cyc - last_rx_cyc >= int'(TMO)) &&
                             (err_cyc - last_rx_cyc <= int'(TMO) + 2)), 32'd1);
      chk("t5_back_idle", 32'(send_state), 32'd0);

      // Reset in the middle of a message
      send_byte(8'h23, 0);
      send_byte(8'h41, 0);
      send_byte(8'h42, 0);
      send_byte(8'h43, 0);
      rst = 1'b1;
      tick(1);
      chk_outputs_zero("t6_rst");
      rst = 1'b0;
      tick(1);
      clear_mon();
      send_byte(8'h41, 2);
      chk("t6_hunt_ignores", 32'(send_state), 32'd0);
      body = '{8'h35};
      build_exp();
      send_msg(0, 1);
      wait_done("t6");
      check_words("t6", 1'b0);

      // Randomized messages with junk between them
      for (int m = 0; m < 20; m++) begin
         int nj;
         nj = $urandom_range(0, 3);
         clear_mon();
         for (int j = 0; j < nj; j++) begin
            logic [7:0] jb;
            do jb = 8'($urandom_range(0, 255)); while (jb == 8'h23);
            send_byte(jb, $urandom_range(0, 2));
         end
         body.delete();
         for (int i = 0, n = $urandom_range(0, 31); i < n; i++) body.push_back(rand_body_byte());
         build_exp();
         send_msg(0, 4);
         wait_done($sformatf("rnd%0d", m));
         check_words($sformatf("rnd%0d", m), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
